vend_controller: RTL and testbench
==================================

// Module: vend_controller
// PURPOSE
//  Sequencing FSM for the guffin vending datapath. Accepts one coin per step and accumulates credit in quarter units.
//  Once credit reaches PRICE_Q it vends one guffin, then pays out change one coin per step, largest coin first.
//  Sits between the debounced step/coin inputs and the credit/change hex display logic.
// PARAMETERS
//  PRICE_Q   4   guffin price in quarters (4 = $1.00); legal range 1..8
//  CW        4   credit/change counter width; must hold PRICE_Q-1+4 (max credit before vend)
// PORTS
//  CLK            in   1   system clock (50 MHz); the only clock
//  RES            in   1   reset, synchronous, active-high
//  step           in   1   one-CLK-cycle advance strobe from the debounced key; all state moves qualify on it
//  quarter_in     in   1   coin present: $0.25
//  halfDollar_in  in   1   coin present: $0.50
//  dollar_in      in   1   coin present: $1.00
//  guffin         out  1   high while in VEND
//  quarter_out    out  1   high while a quarter is being returned
//  halfDollar_out out  1   high while a half-dollar is being returned
//  coin_reject    out  1   high for one step period after a rejected coin presentation
//  busy           out  1   high in VEND or CHANGE; coins are not accepted
//  credit_q       out  CW  current credit in quarters (feeds hex logic)
//  change_q       out  CW  remaining change in quarters
//  state_code     out  2   00 COLLECT, 01 VEND, 10 CHANGE (debug LEDs)
// BEHAVIOUR
//  - Reset: RES high at a CLK edge wins over step.
//    Reset state: COLLECT; credit_q=0, change_q=0; all outputs 0.
//    Reset mid-VEND/CHANGE abandons pending change. This is accepted behaviour.
//  - No change of state occurs unless step=1 at the CLK edge. Outputs are Moore and are held for the whole step period.
//  - Coin value: quarter=1, half=2, dollar=4.
//    Valid = exactly one coin input high.
//    More than one high = illegal: no credit is added and coin_reject=1 until the next step.
//  - COLLECT + step + valid coin:
//    - sum = credit_q + value, computed at CW+1 bits.
//    - sum < PRICE_Q: credit_q <= sum; stay in COLLECT.
//    - sum >= PRICE_Q: change_q <= sum - PRICE_Q; credit_q <= 0; go to VEND.
//  - COLLECT + step + no coin: hold; coin_reject <= 0.
//  - VEND: guffin=1. On step: go to CHANGE if change_q != 0, else go to COLLECT.
//  - CHANGE:
//    - halfDollar_out = (change_q >= 2); quarter_out = (change_q == 1).
//    - On step: change_q decrements by 2 or 1 respectively.
//    - Go to COLLECT when the decremented value is 0.
//  - Coin presented while busy (VEND/CHANGE) on step: ignored; credit unchanged; coin_reject=1 for one step period.
//  - coin_reject is cleared on any step that carries no reject condition.
//  - Exactly one of guffin/quarter_out/halfDollar_out may be high at once. None of them is high in COLLECT.
//  - credit_q never exceeds PRICE_Q-1. change_q never exceeds 3.
//  - No wrap-around is possible for legal PRICE_Q.
// STRUCTURE
//  - vend_pkg: state enum (COLLECT/VEND/CHANGE = 2'b00/01/10) and coin value constants (Q_QUARTER=1, Q_HALF=2, Q_DOLLAR=4).
//  - Sub-module vend_coin_decode (combinational): 3 coin inputs -> value[2:0], valid, illegal.
//  - Top level: one state register, credit/change registers, registered coin_reject, and an output decode.
// TESTING
//  1. RES for 1 cycle with no step, then release -> state_code=00, credit_q=0, all outputs 0.
//  2. quarter,step x4 -> credit_q 1,2,3, then VEND with guffin=1 and change_q=0. Next step -> COLLECT, no coins returned.
//  3. half,step; then dollar,step -> credit 2, then sum 6: VEND with change_q=2.
//     Next step -> CHANGE with halfDollar_out=1. Next step -> COLLECT.
//  4. credit 3; dollar,step -> change_q=3; step -> CHANGE with half_out=1; step -> quarter_out=1; step -> COLLECT.
//  5. quarter+dollar in the same step -> coin_reject=1, credit unchanged. Step in VEND with quarter_in=1 -> coin_reject=1, credit stays 0.
//  6. RES asserted in CHANGE together with step -> next cycle COLLECT, change_q=0. Coins held without step -> no change.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin values for the guffin vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        VEND    = 2'b01,
        CHANGE  = 2'b10
    } vend_state_e;

    localparam logic [2:0] Q_QUARTER = 3'd1;
    localparam logic [2:0] Q_HALF    = 3'd2;
    localparam logic [2:0] Q_DOLLAR  = 3'd4;

endpackage

// File: rtl/vend_coin_decode.sv
// rtl/vend_coin_decode.sv - classifies the three coin-present lines into a quarter value and legality
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic       quarter_i,
    input  logic       half_i,
    input  logic       dollar_i,
    output logic [2:0] value_o,
    output logic       valid_o,
    output logic       illegal_o,
    output logic       any_o
);

    logic [1:0] count;

    assign count     = {1'b0, quarter_i} + {1'b0, half_i} + {1'b0, dollar_i};
    assign valid_o   = (count == 2'd1);
    assign illegal_o = (count > 2'd1);
    assign any_o     = (count != 2'd0);

    always_comb begin
        value_o = 3'd0;
        if (valid_o) begin
            if (quarter_i)   value_o = Q_QUARTER;
            else if (half_i) value_o = Q_HALF;
            else             value_o = Q_DOLLAR;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - step-driven collect/vend/change sequencer with quarter-unit credit and change
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_Q = 4,
    parameter int CW      = 4
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          step,
    input  logic          quarter_in,
    input  logic          halfDollar_in,
    input  logic          dollar_in,
    output logic          guffin,
    output logic          quarter_out,
    output logic          halfDollar_out,
    output logic          coin_reject,
    output logic          busy,
    output logic [CW-1:0] credit_q,
    output logic [CW-1:0] change_q,
    output logic [1:0]    state_code
);

    localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE_Q);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    vend_state_e state_q;
    logic        reject_q;

    logic [2:0]    coin_value;
    logic          coin_valid;
    logic          coin_illegal;
    logic          coin_any;
    logic [CW:0]   sum;
    logic [CW:0]   excess;
    logic [CW-1:0] payout;
    logic [CW-1:0] change_left;

    vend_coin_decode u_decode (
        .quarter_i (quarter_in),
        .half_i    (halfDollar_in),
        .dollar_i  (dollar_in),
        .value_o   (coin_value),
        .valid_o   (coin_valid),
        .illegal_o (coin_illegal),
        .any_o     (coin_any)
    );

    // One extra bit so credit + dollar can never wrap before the price compare.
    assign sum         = {1'b0, credit_q} + (CW+1)'(coin_value);
    assign excess      = sum - PRICE_W;
    assign payout      = (change_q >= TWO_C) ? TWO_C : ONE_C;
    assign change_left = change_q - payout;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            change_q <= '0;
            reject_q <= 1'b0;
        end else if (step) begin
            case (state_q)
                COLLECT: begin
                    reject_q <= coin_illegal;
                    if (coin_valid) begin
                        if (sum >= PRICE_W) begin
                            change_q <= excess[CW-1:0];
                            credit_q <= '0;
                            state_q  <= VEND;
                        end else begin
                            credit_q <= sum[CW-1:0];
                        end
                    end
                end
                VEND: begin
                    reject_q <= coin_any;
                    state_q  <= (change_q != '0) ? CHANGE : COLLECT;
                end
                CHANGE: begin
                    reject_q <= coin_any;
                    change_q <= change_left;
                    if (change_left == '0) state_q <= COLLECT;
                end
                default: begin
                    state_q  <= COLLECT;
                    reject_q <= 1'b0;
                end
            endcase
        end
    end

    assign guffin         = (state_q == VEND);
    assign halfDollar_out = (state_q == CHANGE) && (change_q >= TWO_C);
    assign quarter_out    = (state_q == CHANGE) && (change_q == ONE_C);
    assign busy           = (state_q != COLLECT);
    assign coin_reject    = reject_q;
    assign state_code     = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed-vector bench with a credit/change model checked every cycle
module tb_vend_controller;

    localparam int PRICE = 4;

    logic       CLK = 1'b0;
    logic       RES = 1'b0;
    logic       step = 1'b0;
    logic       quarter_in = 1'b0;
    logic       halfDollar_in = 1'b0;
    logic       dollar_in = 1'b0;
    logic       guffin, quarter_out, halfDollar_out, coin_reject, busy;
    logic [3:0] credit_q, change_q;
    logic [1:0] state_code;

    vend_controller #(.PRICE_Q(PRICE), .CW(4)) dut (
        .CLK            (CLK),
        .RES            (RES),
        .step           (step),
        .quarter_in     (quarter_in),
        .halfDollar_in  (halfDollar_in),
        .dollar_in      (dollar_in),
        .guffin         (guffin),
        .quarter_out    (quarter_out),
        .halfDollar_out (halfDollar_out),
        .coin_reject    (coin_reject),
        .busy           (busy),
        .credit_q       (credit_q),
        .change_q       (change_q),
        .state_code     (state_code)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    // Model: 0 = collecting, 1 = dispensing guffin, 2 = returning change.
    int  m_phase = 0;
    int  m_credit = 0;
    int  m_change = 0;
    bit  m_reject = 0;
    bit  m_valid = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_update(input bit s, input bit q, input bit h, input bit d, input bit r);
        int n;
        int val;
        n   = int'(q) + int'(h) + int'(d);
        val = int'(q) + 2 * int'(h) + 4 * int'(d);
        if (r) begin
            m_phase = 0; m_credit = 0; m_change = 0; m_reject = 0;
            m_valid = 1;
        end else if (s) begin
            if (m_phase == 0) begin
                m_reject = (n > 1);
                if (n == 1) begin
                    if (m_credit + val >= PRICE) begin
                        m_change = m_credit + val - PRICE;
                        m_credit = 0;
                        m_phase  = 1;
                    end else begin
                        m_credit = m_credit + val;
                    end
                end
            end else begin
                m_reject = (n > 0);
                if (m_phase == 1) begin
                    m_phase = (m_change != 0) ? 2 : 0;
                end else begin
                    m_change = m_change - ((m_change >= 2) ? 2 : 1);
                    if (m_change == 0) m_phase = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit s, input bit q, input bit h, input bit d, input bit r);
        step = s; quarter_in = q; halfDollar_in = h; dollar_in = d; RES = r;
        @(posedge CLK);
        model_update(s, q, h, d, r);
        @(negedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (m_valid) begin
            check("state_code", int'(state_code), m_phase);
            check("credit_q", int'(credit_q), m_credit);
            check("change_q", int'(change_q), m_change);
            check("guffin", int'(guffin), int'(m_phase == 1));
            check("halfDollar_out", int'(halfDollar_out), int'(m_phase == 2 && m_change >= 2));
            check("quarter_out", int'(quarter_out), int'(m_phase == 2 && m_change == 1));
            check("busy", int'(busy), int'(m_phase != 0));
            check("coin_reject", int'(coin_reject), int'(m_reject));
        end
    end

    initial begin
        // 1: reset
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("rst_state", int'(state_code), 0);
        check("rst_credit", int'(credit_q), 0);
        check("rst_outs", int'({guffin, quarter_out, halfDollar_out, coin_reject, busy}), 0);

        // 2: four quarters -> exact price
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("t2_credit3", int'(credit_q), 3);
        cyc(1, 1, 0, 0, 0);
        check("t2_guffin", int'(guffin), 1);
        check("t2_change0", int'(change_q), 0);
        cyc(1, 0, 0, 0, 0);
        check("t2_back_collect", int'(state_code), 0);

        // 3: half then dollar -> change of one half
        cyc(1, 0, 1, 0, 0);
        check("t3_credit2", int'(credit_q), 2);
        cyc(1, 0, 0, 1, 0);
        check("t3_change2", int'(change_q), 2);
        cyc(1, 0, 0, 0, 0);
        check("t3_half_out", int'(halfDollar_out), 1);
        cyc(1, 0, 0, 0, 0);
        check("t3_collect", int'(state_code), 0);

        // 4: credit 3 plus dollar -> half then quarter returned
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("t4_change3", int'(change_q), 3);
        cyc(1, 0, 0, 0, 0);
        check("t4_half_out", int'(halfDollar_out), 1);
        cyc(1, 0, 0, 0, 0);
        check("t4_quarter_out", int'(quarter_out), 1);
        cyc(1, 0, 0, 0, 0);
        check("t4_collect", int'(state_code), 0);

        // 5: illegal pair, then coin while busy
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        check("t5_reject", int'(coin_reject), 1);
        check("t5_credit_held", int'(credit_q), 1);
        cyc(0, 0, 0, 0, 0);
        check("t5_reject_held", int'(coin_reject), 1);
        cyc(1, 0, 0, 1, 0);
        check("t5_vend", int'(guffin), 1);
        check("t5_reject_clear", int'(coin_reject), 0);
        cyc(1, 1, 0, 0, 0);
        check("t5_busy_reject", int'(coin_reject), 1);
        check("t5_busy_credit", int'(credit_q), 0);
        cyc(1, 0, 0, 0, 0);

        // 6: reset wins over step in CHANGE; coins without step do nothing
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        check("t6_in_change", int'(state_code), 2);
        cyc(1, 0, 0, 0, 1);
        check("t6_rst_state", int'(state_code), 0);
        check("t6_rst_change", int'(change_q), 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0);
        check("t6_no_step_credit", int'(credit_q), 0);
        check("t6_no_step_reject", int'(coin_reject), 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("t6_vend_after", int'(guffin), 1);
        cyc(1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
